i2c_scl_generator: RTL and testbench

//  I2C master SCL timing engine. Consumes clock_div and stretch_enabled from the master control buffer.

---
 rtl/i2c_scl_generator.sv | 146 ++++++++++++++
 tb/tb_i2c_scl_generator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_generator.sv
// i2c_scl_generator
// I2C master SCL timing engine. Drives SCL open-drain, honours slave clock
// stretching (with an abort timeout) and emits one-cycle strobes for the
// shift/bit FSM at mid-low (data change) and mid-high (SDA sample).
//
// Ports:
//   clk             system clock
//   rst             synchronous, active-high reset
//   clock_div       SCL period in clk cycles; half period = max(clock_div>>1, 2)
//   stretch_enabled 1: wait for the bus to go high after release; 0: ignore scl_in
//   enable          level; keep generating SCL cycles while high
//   scl_in          raw SCL bus level (asynchronous)
//   scl_oe          1 = pull SCL low, 0 = release
//   scl_fall        pulse on the first LOW cycle
//   scl_rise        pulse on the first HIGH cycle
//   shift_strobe    pulse at mid-low
//   sample_strobe   pulse at mid-high
//   stretching      high while a slave holds the released SCL low
//   timeout         pulse when stretching exceeds STRETCH_TIMEOUT cycles
//   busy            high whenever the engine is not idle
module i2c_scl_generator #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned STRETCH_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clock_div,
    input  logic        stretch_enabled,
    input  logic        enable,
    input  logic        scl_in,
    output logic        scl_oe,
    output logic        scl_fall,
    output logic        scl_rise,
    output logic        shift_strobe,
    output logic        sample_strobe,
    output logic        stretching,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        RELEASE,
        HIGH
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(STRETCH_TIMEOUT - 1);

    state_t                 state, state_next;
    logic [31:0]            cnt, cnt_next;
    logic [31:0]            half_q, half_next;
    logic [31:0]            scnt, scnt_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   scl_sync;
    logic [31:0]            half_div;
    logic [31:0]            half_new;
    logic                   phase_end;

    assign scl_sync  = sync[SYNC_STAGES-1];
    assign half_div  = clock_div >> 1;
    assign half_new  = (half_div < 32'd2) ? 32'd2 : half_div;
    assign phase_end = (cnt == half_q - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            half_q <= '0;
            scnt   <= '0;
            sync   <= '1;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            half_q <= half_next;
            scnt   <= scnt_next;
            sync   <= {sync[SYNC_STAGES-2:0], scl_in};
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        half_next  = half_q;
        scnt_next  = scnt;
        stretching = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = LOW;
                    cnt_next   = '0;
                    half_next  = half_new;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_next = RELEASE;
                    cnt_next   = '0;
                    scnt_next  = '0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            RELEASE: begin
                // Synchronizer lag means even an unstretched bus reads low
                // for SYNC_STAGES cycles here; those count as wait cycles.
                if (!stretch_enabled || scl_sync) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    stretching = 1'b1;
                    if (scnt == TIMEOUT_LAST) begin
                        timeout    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        scnt_next = scnt + 32'd1;
                    end
                end
            end
            HIGH: begin
                if (phase_end) begin
                    cnt_next = '0;
                    if (enable) begin
                        state_next = LOW;
                        half_next  = half_new;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobe positions never coincide: half_q >= 2 keeps mid-phase off cnt 0.
    assign scl_oe        = (state == LOW);
    assign scl_fall      = (state == LOW)  && (cnt == 32'd0);
    assign shift_strobe  = (state == LOW)  && (cnt == (half_q >> 1));
    assign scl_rise      = (state == HIGH) && (cnt == 32'd0);
    assign sample_strobe = (state == HIGH) && (cnt == (half_q >> 1));
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_i2c_scl_generator.sv
module tb_i2c_scl_generator;

    localparam int unsigned S  = 2;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] clock_div;
    logic        stretch_enabled;
    logic        enable;
    logic        scl_in;
    logic        scl_oe, scl_fall, scl_rise, shift_strobe, sample_strobe;
    logic        stretching, timeout, busy;

    i2c_scl_generator #(
        .SYNC_STAGES(S),
        .STRETCH_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clock_div(clock_div),
        .stretch_enabled(stretch_enabled),
        .enable(enable),
        .scl_in(scl_in),
        .scl_oe(scl_oe),
        .scl_fall(scl_fall),
        .scl_rise(scl_rise),
        .shift_strobe(shift_strobe),
        .sample_strobe(sample_strobe),
        .stretching(stretching),
        .timeout(timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_FALL, EV_SHIFT, EV_RISE, EV_SAMPLE, EV_TIMEOUT} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int unsigned t;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned hold_q[$];
    int unsigned cyc = 0;
    int unsigned hold_left = 0;
    bit          armed = 0;
    bit          mon_en = 0;
    int unsigned oe_cnt = 0;
    int unsigned str_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus: open-drain wire pulled up, master pulls low via scl_oe, slave
    // keeps it low for a per-release number of cycles taken from hold_q.
    assign scl_in = !scl_oe && (hold_left == 0);

    always @(negedge clk) begin
        if (scl_oe) begin
            hold_left = 0;
            armed = 1;
        end else if (armed) begin
            armed = 0;
            hold_left = (hold_q.size() > 0) ? hold_q.pop_front() : 0;
        end else if (hold_left > 0) begin
            hold_left = hold_left - 1;
        end
    end

    task automatic chk(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_ev(input ev_kind_t kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %s at %0d expected none", kind.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.t != cyc) begin
                errors++;
                $display("FAIL event: got %s at %0d expected %s at %0d",
                         kind.name(), cyc, e.kind.name(), e.t);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            int n;
            n = int'(scl_fall) + int'(shift_strobe) + int'(scl_rise)
              + int'(sample_strobe) + int'(timeout);
            if (n > 0) chk("strobe_excl", n, 1);
            if (scl_fall)      check_ev(EV_FALL);
            if (shift_strobe)  check_ev(EV_SHIFT);
            if (scl_rise)      check_ev(EV_RISE);
            if (sample_strobe) check_ev(EV_SAMPLE);
            if (timeout)       check_ev(EV_TIMEOUT);
            if (scl_oe)     oe_cnt++;
            if (stretching) str_cnt++;
        end
    end

    function automatic int unsigned half_of(input int unsigned d);
        int unsigned h;
        h = d / 2;
        return (h < 2) ? 2 : h;
    endfunction

    task automatic wait_until(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input int unsigned t);
        ev_t e;
        e.kind = k;
        e.t = t;
        exp_q.push_back(e);
    endtask

    // One burst of n SCL cycles: clock_div d1 for the first cycle, d2 after;
    // h[i] is how long the slave holds SCL low after the i-th release.
    task automatic run_burst(input int unsigned d1, input int unsigned d2,
                             input int unsigned n, input bit sen,
                             input int unsigned h [4]);
        int unsigned t0, t, t_last, hh, rel, w, rise, exp_oe, exp_str;
        @(posedge clk);
        #1;
        t0 = cyc;
        clock_div = d1;
        stretch_enabled = sen;
        oe_cnt = 0;
        str_cnt = 0;
        exp_oe = 0;
        exp_str = 0;
        t = t0 + 1;
        t_last = t;
        for (int i = 0; i < int'(n); i++) begin
            hold_q.push_back(h[i]);
            hh = half_of((i == 0) ? d1 : d2);
            t_last = t;
            push_ev(EV_FALL, t);
            push_ev(EV_SHIFT, t + hh / 2);
            exp_oe += hh;
            rel = t + hh;
            if (sen) begin
                w = h[i] + S;
                if (w >= TO) begin
                    push_ev(EV_TIMEOUT, rel + TO - 1);
                    exp_str += TO;
                    t = rel + TO + 1;
                    continue;
                end
                exp_str += w;
                rise = rel + w + 1;
            end else begin
                rise = rel + 1;
            end
            push_ev(EV_RISE, rise);
            push_ev(EV_SAMPLE, rise + hh / 2);
            t = rise + hh;
        end
        enable = 1'b1;
        wait_until(t0 + 1);
        clock_div = d2;
        wait_until(t_last);
        enable = 1'b0;
        wait_until(t);
        @(negedge clk);
        #1;
        chk("end_busy", busy, 0);
        chk("end_scl_oe", scl_oe, 0);
        chk("end_pending_events", exp_q.size(), 0);
        chk("low_cycles", oe_cnt, exp_oe);
        chk("stretch_cycles", str_cnt, exp_str);
        exp_q.delete();
        hold_q.delete();
    endtask

    // Start an 8-divider cycle, pulse rst at cycle t0+offset, check the
    // following cycle is idle and quiet, then let it rest.
    task automatic reset_mid(input int unsigned offset, input string tag);
        int unsigned t0;
        int quiet;
        mon_en = 0;
        @(posedge clk);
        #1;
        t0 = cyc;
        clock_div = 8;
        stretch_enabled = 1'b1;
        enable = 1'b1;
        wait_until(t0 + offset);
        rst = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_scl_oe"}, scl_oe, 0);
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            quiet += int'(scl_fall) + int'(shift_strobe) + int'(scl_rise)
                   + int'(sample_strobe) + int'(timeout) + int'(stretching);
            @(negedge clk);
        end
        chk({tag, "_quiet"}, quiet, 0);
        hold_q.delete();
        mon_en = 1;
    endtask

    int unsigned hv [4];

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        clock_div = 8;
        stretch_enabled = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", int'(scl_fall) + int'(shift_strobe) + int'(scl_rise)
                           + int'(sample_strobe) + int'(timeout) + int'(stretching), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1;

        hv = '{0, 0, 0, 0};
        run_burst(8, 8, 3, 1'b1, hv);          // plain three cycles
        hv = '{12, 0, 0, 0};
        run_burst(8, 8, 1, 1'b1, hv);          // honoured stretch
        hv = '{20, 0, 0, 0};
        run_burst(8, 8, 1, 1'b0, hv);          // stretch ignored
        hv = '{1000, 0, 0, 0};
        run_burst(8, 8, 2, 1'b1, hv);          // timeout then restart
        hv = '{0, 0, 0, 0};
        run_burst(2, 2, 2, 1'b1, hv);          // clamp
        run_burst(1, 1, 2, 1'b0, hv);
        run_burst(0, 0, 1, 1'b1, hv);
        run_burst(9, 9, 2, 1'b1, hv);          // odd truncates
        run_burst(8, 16, 2, 1'b1, hv);         // divider change mid-LOW

        reset_mid(6, "rst_release");
        reset_mid(9, "rst_high");
        run_burst(8, 8, 2, 1'b1, hv);          // clean restart

        for (int b = 0; b < 30; b++) begin
            int unsigned d1, d2, n;
            bit sen;
            d1 = ($urandom % 5 == 0) ? $urandom_range(0, 3) : $urandom_range(4, 24);
            d2 = ($urandom % 5 == 0) ? $urandom_range(0, 3) : $urandom_range(4, 24);
            n = $urandom_range(1, 4);
            sen = 1'($urandom % 2);
            for (int i = 0; i < 4; i++) begin
                case ($urandom % 6)
                    0: hv[i] = $urandom_range(10, 20);
                    1: hv[i] = 1000;
                    default: hv[i] = $urandom_range(0, 4);
                endcase
            end
            run_burst(d1, d2, n, sen, hv);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
